// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit validation, optional parity, sticky error flags and an RX FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around mid-bit.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 38400,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rxd,
    input  logic                                 rd_en,
    output logic [DATA_BITS-1:0]                 rd_data,
    output logic                                 empty,
    output logic                                 full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 frame_err,
    output logic                                 parity_err,
    output logic                                 overrun,
    input  logic                                 clr_err
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic             PAR_EN   = (PARITY != 0);
    localparam logic             PAR_ODD  = (PARITY == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

    state_e                 state_q, state_d;
    logic                   sync_q, line_q, prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   s_mid_q, bit_val, dec;
    logic                   wr, set_fe, set_pe, set_ov, do_wr, do_rd;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   fe_q, pe_q, ov_q;

    // Every bit is decided at HALF+1 so both sampling builds share one latency.
    assign dec = (cnt_q == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_LO = CNT_W'(HALF - 1);
    logic s_lo_q;
    always_ff @(posedge clk) begin
        if (!rst_n)                s_lo_q <= 1'b1;
        else if (cnt_q == CNT_LO)  s_lo_q <= line_q;
    end
    assign bit_val = (s_lo_q & s_mid_q) | (s_lo_q & line_q) | (s_mid_q & line_q);
`else
    assign bit_val = s_mid_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        wr        = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (prev_q && !line_q) state_d = StStart;
            end
            StStart: begin
                if (dec) begin
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                    state_d   = bit_val ? StIdle : StData;
                end
            end
            StData: begin
                if (dec) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? StParity : StStop;
                end
            end
            StParity: begin
                if (dec) begin
                    par_bad_d = ((^shift_q) ^ bit_val) != PAR_ODD;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (dec) begin
                    if (!bit_val) begin
                        set_fe  = 1'b1;
                        state_d = StWaitHi;
                    end else begin
                        set_pe  = par_bad_q;
                        wr      = !par_bad_q;
                        state_d = StIdle;
                    end
                end
            end
            StWaitHi: begin
                cnt_d = '0;
                if (line_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign set_ov  = wr && full && !do_rd;

    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ov_q;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sync_q    <= 1'b1;
            line_q    <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            s_mid_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= rxd;
            line_q    <= sync_q;
            prev_q    <= line_q;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            if (cnt_q == CNT_MID) s_mid_q <= line_q;
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_q + CW'(do_wr) - CW'(do_rd);
            // A new error in the same cycle as clr_err keeps the flag set.
            fe_q      <= set_fe | (fe_q & !clr_err);
            pe_q      <= set_pe | (pe_q & !clr_err);
            ov_q      <= set_ov | (ov_q & !clr_err);
        end
    end

endmodule
